// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serializes WIDTH-bit frames LSB first. A one-entry holding
// buffer lets the next frame follow the current one with no gap cycle.
module serial_frame_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             last,
  output logic [7:0]       frames_sent
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             hold_full;
  logic             transfer;
  logic             at_last;

  // Ready depends only on registered buffer occupancy, never on load_valid.
  assign load_ready = ~hold_full;
  assign transfer   = load_valid & load_ready;
  assign at_last    = (state == SHIFT) && (bit_cnt == LAST_CNT);

  // State register; reset aborts whatever frame is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Leave SHIFT only when the last bit goes out and nothing is queued or offered.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (transfer) next_state = SHIFT;
      SHIFT:   if (at_last && !hold_full && !transfer) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Serial outputs are active only while a frame is shifting.
  always_comb begin
    serial_out = 1'b0;
    bit_valid  = 1'b0;
    last       = 1'b0;
    if (state == SHIFT) begin
      serial_out = shift_reg[0];
      bit_valid  = 1'b1;
      last       = at_last;
    end
  end

  // Datapath: shifter, bit counter, holding buffer and completed-frame count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg   <= '0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      frames_sent <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (transfer) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (at_last) begin
            frames_sent <= frames_sent + 8'd1;
            bit_cnt     <= '0;
            if (hold_full) begin
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
            end else if (transfer) begin
              shift_reg <= data_in;
            end
          end else begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (transfer) begin
              hold_reg  <= data_in;
              hold_full <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed and randomized checks of serial_frame_tx against
// a queue-based frame model.
module tb_serial_frame_tx;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         bit_valid;
  logic         last;
  logic [7:0]   frames_sent;

  int tests = 0;
  int fails = 0;

  // Model state: frame being sent, bits still to send, frames waiting to start.
  logic [W-1:0] m_cur;
  int           m_rem;
  logic [W-1:0] m_pending[$];
  logic [7:0]   m_frames;

  // Values sampled from the DUT and predicted by the model each cycle.
  logic       obs_serial, obs_bv, obs_last, obs_ready;
  logic [7:0] obs_frames;
  logic       exp_serial, exp_bv, exp_last, exp_ready;
  logic [7:0] exp_frames;
  logic       xfer;

  serial_frame_tx #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .serial_out  (serial_out),
    .bit_valid   (bit_valid),
    .last        (last),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_cur    = '0;
    m_rem    = 0;
    m_pending.delete();
    m_frames = 8'd0;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, sample at negedge, advance the model at posedge.
  task automatic cycle(input logic lv, input logic [W-1:0] d);
    load_valid = lv;
    data_in    = d;
    @(negedge clk);
    obs_serial = serial_out;
    obs_bv     = bit_valid;
    obs_last   = last;
    obs_ready  = load_ready;
    obs_frames = frames_sent;
    exp_bv     = (m_rem > 0);
    exp_last   = (m_rem == 1);
    exp_serial = exp_bv ? m_cur[W - m_rem] : 1'b0;
    exp_ready  = (m_pending.size() == 0);
    exp_frames = m_frames;
    xfer       = lv && exp_ready;
    @(posedge clk);
    if (m_rem > 0) begin
      if (m_rem == 1) begin
        m_frames = m_frames + 8'd1;
        if (m_pending.size() > 0) begin
          m_cur = m_pending.pop_front();
          m_rem = W;
        end else if (xfer) begin
          m_cur = d;
          m_rem = W;
        end else begin
          m_rem = 0;
        end
      end else begin
        m_rem = m_rem - 1;
        if (xfer) m_pending.push_back(d);
      end
    end else if (xfer) begin
      m_cur = d;
      m_rem = W;
    end
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    #1;
    tests++;
    if ({serial_out, bit_valid, last, load_ready} !== 4'b0001 || frames_sent !== 8'd0)
      $display("[TB] FAIL reset_outputs: got so=%b bv=%b last=%b rdy=%b fs=%0d, required so=0 bv=0 last=0 rdy=1 fs=0",
               serial_out, bit_valid, last, load_ready, frames_sent);
    if ({serial_out, bit_valid, last, load_ready} !== 4'b0001 || frames_sent !== 8'd0) fails++;
    apply_reset();
  endtask

  task automatic test_single_frame();
    logic [3:0] pat;
    pat = 4'b0111;
    apply_reset();
    cycle(1'b1, pat);
    tests++;
    if (obs_ready !== 1'b1 || obs_bv !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_first_accept: got rdy=%b bv=%b, required rdy=1 bv=0", obs_ready, obs_bv);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0);
      tests++;
      if (obs_bv !== 1'b1 || obs_serial !== pat[k] || obs_last !== (k == 3)) begin
        fails++;
        $display("[TB] FAIL single_bit%0d: got bv=%b so=%b last=%b, required bv=1 so=%b last=%b",
                 k, obs_bv, obs_serial, obs_last, pat[k], (k == 3));
      end
    end
    cycle(1'b0, '0);
    tests++;
    if (obs_bv !== 1'b0 || obs_frames !== 8'd1) begin
      fails++;
      $display("[TB] FAIL single_done: got bv=%b fs=%0d, required bv=0 fs=1", obs_bv, obs_frames);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    seq = 8'b00111010;
    apply_reset();
    cycle(1'b1, 4'b1010);
    for (int i = 0; i < 8; i++) begin
      cycle(i == 1, 4'b0011);
      tests++;
      if (obs_bv !== 1'b1 || obs_serial !== seq[i] || obs_serial !== exp_serial) begin
        fails++;
        $display("[TB] FAIL b2b_bit%0d: got bv=%b so=%b, required bv=1 so=%b", i, obs_bv, obs_serial, seq[i]);
      end
    end
    cycle(1'b0, '0);
    tests++;
    if (obs_bv !== 1'b0 || obs_frames !== 8'd2) begin
      fails++;
      $display("[TB] FAIL b2b_done: got bv=%b fs=%0d, required bv=0 fs=2", obs_bv, obs_frames);
    end
  endtask

  task automatic test_hold_full();
    logic [W-1:0] f[3];
    logic [12:0]  ready_seq;
    logic         want_bit;
    int           n_acc;
    ready_seq = 13'b1111000100011;
    for (int j = 0; j < 3; j++) f[j] = W'($urandom);
    n_acc = 0;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(n_acc < 3, (n_acc < 3) ? f[n_acc] : '0);
      if (xfer) n_acc++;
      want_bit = (i == 0) ? 1'b0 : f[(i - 1) / 4][(i - 1) % 4];
      tests++;
      if (obs_ready !== ready_seq[i] || obs_bv !== (i != 0) || obs_serial !== want_bit) begin
        fails++;
        $display("[TB] FAIL hold_cycle%0d: got rdy=%b bv=%b so=%b, required rdy=%b bv=%b so=%b",
                 i, obs_ready, obs_bv, obs_serial, ready_seq[i], (i != 0), want_bit);
      end
    end
    cycle(1'b0, '0);
    tests++;
    if (obs_bv !== 1'b0 || obs_frames !== 8'd3) begin
      fails++;
      $display("[TB] FAIL hold_done: got bv=%b fs=%0d, required bv=0 fs=3", obs_bv, obs_frames);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] f1, f2;
    logic         want_bit;
    f1 = W'($urandom);
    f2 = W'($urandom);
    apply_reset();
    cycle(1'b1, f1);
    for (int i = 0; i < 8; i++) begin
      cycle(i == 3, f2);
      want_bit = (i < 4) ? f1[i] : f2[i - 4];
      tests++;
      if (obs_bv !== 1'b1 || obs_serial !== want_bit || (i == 3 && (obs_last !== 1'b1 || obs_ready !== 1'b1))) begin
        fails++;
        $display("[TB] FAIL bypass_bit%0d: got bv=%b so=%b last=%b rdy=%b, required bv=1 so=%b",
                 i, obs_bv, obs_serial, obs_last, obs_ready, want_bit);
      end
    end
    cycle(1'b0, '0);
    tests++;
    if (obs_bv !== 1'b0 || obs_frames !== 8'd2) begin
      fails++;
      $display("[TB] FAIL bypass_done: got bv=%b fs=%0d, required bv=0 fs=2", obs_bv, obs_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    cycle(1'b1, 4'b1101);
    cycle(1'b1, 4'b0110);
    cycle(1'b0, '0);
    tests++;
    if (obs_ready !== 1'b0 || obs_bv !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_pre: got rdy=%b bv=%b, required rdy=0 bv=1", obs_ready, obs_bv);
    end
    reset = 1'b0;
    #2;
    tests++;
    if ({serial_out, bit_valid, last, load_ready} !== 4'b0001 || frames_sent !== 8'd0) begin
      fails++;
      $display("[TB] FAIL midreset_async: got so=%b bv=%b last=%b rdy=%b fs=%0d, required so=0 bv=0 last=0 rdy=1 fs=0",
               serial_out, bit_valid, last, load_ready, frames_sent);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    tests++;
    if (obs_bv !== 1'b0 || obs_ready !== 1'b1 || obs_frames !== 8'd0) begin
      fails++;
      $display("[TB] FAIL midreset_after: got bv=%b rdy=%b fs=%0d, required bv=0 rdy=1 fs=0", obs_bv, obs_ready, obs_frames);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, W'($urandom));
      tests++;
      if (obs_serial !== exp_serial || obs_bv !== exp_bv || obs_last !== exp_last ||
          obs_ready !== exp_ready || obs_frames !== exp_frames) begin
        fails++;
        $display("[TB] FAIL random_cycle%0d: got so=%b bv=%b last=%b rdy=%b fs=%0d, required so=%b bv=%b last=%b rdy=%b fs=%0d",
                 i, obs_serial, obs_bv, obs_last, obs_ready, obs_frames,
                 exp_serial, exp_bv, exp_last, exp_ready, exp_frames);
      end
    end
  endtask

  task automatic test_wrap();
    int  n_acc;
    int  guard;
    bit  saw_255;
    n_acc   = 0;
    guard   = 0;
    saw_255 = 0;
    apply_reset();
    while (n_acc < 256 && guard < 3000) begin
      cycle(1'b1, W'($urandom));
      if (xfer) n_acc++;
      guard++;
      if (exp_frames == 8'd255 && !saw_255) begin
        saw_255 = 1;
        tests++;
        if (obs_frames !== 8'd255) begin
          fails++;
          $display("[TB] FAIL wrap_255: got fs=%0d, required fs=255", obs_frames);
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0);
      if (!exp_bv) break;
    end
    tests++;
    if (n_acc != 256 || obs_bv !== 1'b0 || obs_frames !== 8'd0) begin
      fails++;
      $display("[TB] FAIL wrap_zero: got accepted=%0d bv=%b fs=%0d, required accepted=256 bv=0 fs=0",
               n_acc, obs_bv, obs_frames);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hold_full();
    test_bypass();
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
